// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-lite encodings, slave FSM state constants and byte-lane helpers
// used by the SRAM responder and its memory macro.
package ahb_sram_slave_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

    // Little-endian lane select: the byte at addr_lo==0 lives in bits [7:0].
    function automatic logic [3:0] be_decode(input logic [2:0] hsize,
                                             input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        case (hsize)
            HSIZE_BYTE: be = 4'b0001 << addr_lo;
            HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic xfer_illegal(input logic [2:0] hsize,
                                          input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b1;
        case (hsize)
            HSIZE_BYTE: bad = 1'b0;
            HSIZE_HALF: bad = addr_lo[0];
            HSIZE_WORD: bad = (addr_lo != 2'b00);
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Single-port-write / single-port-read synchronous SRAM, 32-bit words with
// byte enables and a registered read port that clears on reset.
module ahb_sram_mem
    import ahb_sram_slave_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                     hclk,
    input  logic                     hresetn,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [3:0]               wbe,
    input  logic [31:0]              wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge hclk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wbe[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read-first: a same-edge write is not visible here; the top merges it.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-lite SRAM responder: address-phase capture, wait/error FSM and
// read-after-write forwarding around a byte-writable synchronous SRAM.
module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int         AW = $clog2(DEPTH);
    localparam logic [2:0] WS = 3'(WAIT_STATES);

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [2:0]    acc_state;
    logic [2:0]    wcnt;

    logic          accept;
    logic          req_bad;
    logic          good_acc;

    logic          write_p1;
    logic [AW-1:0] addr_p1;
    logic [3:0]    be_p1;
    logic [31:0]   fwd_mask_p1;
    logic [31:0]   fwd_data_p1;

    logic          wr_en;
    logic          rd_now;
    logic          rd_wait;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [31:0]   mem_rdata;

    // ---- address phase: qualify and classify the incoming transfer ----
    assign accept = hsel && hready
                 && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ)
                 && (state == ST_IDLE || state == ST_DATA || state == ST_ERR2);

    // DEPTH is a power of two, so any set bit above the word index is out of range.
    assign req_bad   = xfer_illegal(hsize, haddr[1:0]) || (haddr[31:AW+2] != '0);
    assign good_acc  = accept && !req_bad;
    assign acc_state = req_bad ? ST_ERR1 : ((WS != 3'd0) ? ST_WAIT : ST_DATA);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept) begin
                    state_nxt = acc_state;
                end else if (hready) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wcnt == 3'd1) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---- data phase: commit writes, launch reads ----
    assign wr_en   = (state == ST_DATA) && hready && write_p1;
    assign rd_now  = good_acc && !hwrite && (WS == 3'd0);
    assign rd_wait = (state == ST_WAIT) && (wcnt == 3'd1) && !write_p1;
    assign rd_en   = rd_now || rd_wait;
    assign rd_addr = rd_now ? haddr[AW+1:2] : addr_p1;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state       <= ST_IDLE;
            wcnt        <= '0;
            write_p1    <= 1'b0;
            fwd_mask_p1 <= '0;
        end else begin
            state <= state_nxt;
            if (good_acc) begin
                wcnt     <= WS;
                write_p1 <= hwrite;
            end else if (state == ST_WAIT) begin
                wcnt <= wcnt - 3'd1;
            end
            if (rd_en) begin
                fwd_mask_p1 <= (wr_en && (rd_addr == addr_p1)) ? be_mask(be_p1) : '0;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (good_acc) begin
            addr_p1 <= haddr[AW+1:2];
            be_p1   <= be_decode(hsize, haddr[1:0]);
        end
        if (rd_en) begin
            fwd_data_p1 <= hwdata;
        end
    end

    ahb_sram_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .hclk    (hclk),
        .hresetn (hresetn),
        .we      (wr_en),
        .waddr   (addr_p1),
        .wbe     (be_p1),
        .wdata   (hwdata),
        .re      (rd_en),
        .raddr   (rd_addr),
        .rdata   (mem_rdata)
    );

    // ---- response: outputs decode from registered state only ----
    assign hreadyout = !(state == ST_WAIT || state == ST_ERR1);
    assign hresp     = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign hrdata    = (mem_rdata & ~fwd_mask_p1) | (fwd_data_p1 & fwd_mask_p1);

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Random and directed bus traffic against two responders (zero-wait and
// three-wait) compared with an in-order word-array model of the SRAM.
module tb_ahb_sram_slave;

    localparam int DEPTH = 64;
    localparam int WS1   = 3;

    typedef struct {
        bit        sel;
        bit [1:0]  trans;
        bit        wr;
        bit [2:0]  size;
        bit [31:0] addr;
        bit [31:0] wdata;
    } xfer_t;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        hsel_m;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    int          cur = 0;

    logic        hsel0, hsel1, hro0, hro1, hresp0, hresp1;
    logic [31:0] hrd0, hrd1;
    logic        bus_hready, bus_hresp;
    logic [31:0] bus_hrdata;

    assign hsel0      = hsel_m && (cur == 0);
    assign hsel1      = hsel_m && (cur == 1);
    assign bus_hready = (cur == 1) ? hro1 : hro0;
    assign bus_hresp  = (cur == 1) ? hresp1 : hresp0;
    assign bus_hrdata = (cur == 1) ? hrd1 : hrd0;

    always #5 hclk = ~hclk;

    ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hro0),
        .hreadyout(hro0), .hresp(hresp0), .hrdata(hrd0)
    );

    ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(WS1)) u_dut1 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hro1),
        .hreadyout(hro1), .hresp(hresp1), .hrdata(hrd1)
    );

    bit [31:0] model [2][DEPTH];
    bit [31:0] last_rd [2];
    xfer_t     q[$];
    int        n_checks = 0;
    int        n_fail = 0;
    bit        abort = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (dut %0d, t=%0t)", tag, got, exp, cur, $time);
        end
    endtask

    function automatic xfer_t mk(input bit wr, input bit [2:0] size, input bit [31:0] addr,
                                 input bit [31:0] wdata);
        xfer_t x;
        x.sel = 1'b1; x.trans = 2'b10; x.wr = wr; x.size = size; x.addr = addr; x.wdata = wdata;
        return x;
    endfunction

    function automatic xfer_t mk_nop(input bit sel, input bit [1:0] trans);
        xfer_t x;
        x.sel = sel; x.trans = trans; x.wr = 1'($urandom_range(0, 1)); x.size = 3'd2;
        x.addr = 32'($urandom_range(0, DEPTH - 1) * 4); x.wdata = $urandom;
        return x;
    endfunction

    function automatic bit is_act(input xfer_t x);
        return x.sel && (x.trans == 2'b10 || x.trans == 2'b11);
    endfunction

    function automatic bit is_bad(input xfer_t x);
        int unsigned nbytes;
        if (x.size > 3'd2) return 1'b1;
        nbytes = 32'd1 << x.size;
        if ((x.addr % nbytes) != 0) return 1'b1;
        return (x.addr >> 2) >= DEPTH;
    endfunction

    function automatic void model_write(input int d, input xfer_t x);
        int w, lo, n;
        w  = int'(x.addr >> 2);
        lo = int'(x.addr % 4);
        n  = 1 << x.size;
        for (int b = lo; b < lo + n; b++) model[d][w][8*b +: 8] = x.wdata[8*b +: 8];
    endfunction

    function automatic xfer_t rand_xfer();
        xfer_t x;
        int r, w, lo;
        r = int'($urandom_range(0, 99));
        if (r < 4) return mk_nop(1'b0, 2'($urandom_range(2, 3)));
        if (r < 8) return mk_nop(1'b1, 2'($urandom_range(0, 1)));
        x.sel   = 1'b1;
        x.trans = $urandom_range(0, 1) ? 2'b10 : 2'b11;
        x.wr    = 1'($urandom_range(0, 1));
        x.wdata = $urandom;
        r = int'($urandom_range(0, 99));
        x.size = (r < 5) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        r = int'($urandom_range(0, 99));
        if (r < 55)      w = int'($urandom_range(0, 3));
        else if (r < 60) w = DEPTH + int'($urandom_range(0, 3));
        else             w = int'($urandom_range(0, DEPTH - 1));
        if ($urandom_range(0, 99) < 5)  lo = int'($urandom_range(0, 3));
        else if (x.size == 3'd0)        lo = int'($urandom_range(0, 3));
        else if (x.size == 3'd1)        lo = 2 * int'($urandom_range(0, 1));
        else                            lo = 0;
        x.addr = 32'(w * 4 + lo);
        return x;
    endfunction

    task automatic drive_ap(input xfer_t x);
        hsel_m = x.sel; htrans = x.trans; hwrite = x.wr; hsize = x.size; haddr = x.addr;
    endtask

    task automatic complete(input xfer_t x, input int stall, input int resp_err);
        bit act, err;
        int exp_st, w;
        act    = is_act(x);
        err    = act && is_bad(x);
        exp_st = !act ? 0 : (err ? 1 : ((cur == 1) ? WS1 : 0));
        check_eq("stall_cycles", 32'(stall), 32'(exp_st));
        check_eq("stall_resp", 32'(resp_err), 32'd0);
        check_eq("resp", 32'(bus_hresp), 32'(err));
        if (act && !err && !x.wr) begin
            w = int'(x.addr >> 2);
            check_eq("rdata", bus_hrdata, model[cur][w]);
            last_rd[cur] = model[cur][w];
        end else begin
            check_eq("rdata_hold", bus_hrdata, last_rd[cur]);
        end
        if (act && !err && x.wr) model_write(cur, x);
    endtask

    // Pipelined master: the address phase advances and the data phase retires
    // only on edges where the bus hready is high.
    task automatic run_queue();
        xfer_t ap, dp;
        bit    dp_v, rdy, done;
        int    stall, resp_err;
        if (abort) begin q.delete(); return; end
        q.push_back(mk_nop(1'b0, 2'b00));
        q.push_back(mk_nop(1'b0, 2'b00));
        ap = q.pop_front();
        drive_ap(ap);
        dp = ap; dp_v = 1'b0; done = 1'b0; stall = 0; resp_err = 0;
        while (!done) begin
            @(negedge hclk);
            rdy = bus_hready;
            if (!rdy) begin
                stall++;
                if (dp_v && (bus_hresp !== (is_act(dp) && is_bad(dp)))) resp_err++;
                if (stall > 16) begin
                    check_eq("stall_bound", 32'(stall), 32'd16);
                    abort = 1'b1;
                    q.delete();
                    return;
                end
            end else if (dp_v) begin
                complete(dp, stall, resp_err);
            end
            @(posedge hclk); #1;
            if (rdy) begin
                dp = ap; dp_v = 1'b1; stall = 0; resp_err = 0;
                hwdata = dp.wdata;
                if (q.size() == 0) done = 1'b1;
                else begin ap = q.pop_front(); drive_ap(ap); end
            end
        end
    endtask

    task automatic preload();
        for (int w = 0; w < DEPTH; w++) q.push_back(mk(1'b1, 3'd2, 32'(w * 4), $urandom));
        run_queue();
    endtask

    task automatic random_traffic(input int n);
        for (int i = 0; i < n; i++) q.push_back(rand_xfer());
        run_queue();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hsel_m = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2; hwdata = '0;
        last_rd[0] = '0; last_rd[1] = '0;
        #12;
        check_eq("rst_hreadyout0", 32'(hro0), 32'd1);
        check_eq("rst_hresp0", 32'(hresp0), 32'd0);
        check_eq("rst_hrdata0", hrd0, 32'd0);
        check_eq("rst_hreadyout1", 32'(hro1), 32'd1);
        check_eq("rst_hresp1", 32'(hresp1), 32'd0);
        check_eq("rst_hrdata1", hrd1, 32'd0);
        @(posedge hclk); #1;
        hresetn = 1'b1;

        // zero-wait responder
        cur = 0;
        preload();
        q.push_back(mk(1'b1, 3'd2, 32'h10, 32'hDEADBEEF));
        q.push_back(mk(1'b0, 3'd2, 32'h10, 32'h0));
        run_queue();
        check_eq("raw_forward", bus_hrdata, 32'hDEADBEEF);

        q.push_back(mk(1'b1, 3'd2, 32'h20, 32'h0000_0000));
        q.push_back(mk(1'b1, 3'd0, 32'h21, 32'h0000_AA00));
        q.push_back(mk(1'b1, 3'd1, 32'h22, 32'h1234_0000));
        q.push_back(mk(1'b0, 3'd2, 32'h20, 32'h0));
        run_queue();
        check_eq("byte_half_merge", bus_hrdata, 32'h1234AA00);

        q.push_back(mk(1'b0, 3'd2, 32'h14, 32'h0));
        q.push_back(mk(1'b0, 3'd2, 32'h13, 32'h0));
        q.push_back(mk(1'b1, 3'd2, 32'(DEPTH * 4), 32'hFFFF_FFFF));
        q.push_back(mk(1'b0, 3'd2, 32'h00, 32'h0));
        q.push_back(mk_nop(1'b0, 2'b10));
        q.push_back(mk_nop(1'b1, 2'b00));
        q.push_back(mk_nop(1'b1, 2'b01));
        run_queue();
        random_traffic(300);

        // three-wait responder
        cur = 1;
        preload();
        q.push_back(mk(1'b0, 3'd2, 32'h10, 32'h0));
        q.push_back(mk(1'b0, 3'd2, 32'h14, 32'h0));
        q.push_back(mk(1'b0, 3'd2, 32'h13, 32'h0));
        run_queue();
        random_traffic(300);

        // reset in the middle of a stalled write
        q.push_back(mk(1'b1, 3'd2, 32'h08, 32'h5A5AC3C3));
        q.push_back(mk(1'b0, 3'd2, 32'h08, 32'h0));
        run_queue();
        drive_ap(mk(1'b1, 3'd2, 32'h08, 32'h0));
        @(posedge hclk); #1;
        drive_ap(mk_nop(1'b0, 2'b00));
        hwdata = 32'h0BADF00D;
        @(negedge hclk);
        check_eq("pre_rst_stalled", 32'(bus_hready), 32'd0);
        hresetn = 1'b0;
        #1;
        check_eq("async_rst_hreadyout", 32'(bus_hready), 32'd1);
        check_eq("async_rst_hresp", 32'(bus_hresp), 32'd0);
        check_eq("async_rst_hrdata", bus_hrdata, 32'd0);
        @(posedge hclk); #1;
        hresetn = 1'b1;
        last_rd[0] = '0; last_rd[1] = '0;
        q.push_back(mk(1'b0, 3'd2, 32'h08, 32'h0));
        run_queue();
        check_eq("dropped_write", bus_hrdata, 32'h5A5AC3C3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
